operand_fwd_unit: RTL and testbench
===================================

Name: operand_fwd_unit

Overview:
- Parametrised operand-forwarding and hazard block for the 5-stage MIPS pipeline; generalises the fixed 3-input forwarding mux.
- Tracks destination registers of DEPTH in-flight instructions (slot0=EX, slot1=MEM, slot2=WB by default) in an internal shift register.
- Resolves each of NUM_SRC ID-stage source operands against the tracked slots and raises a load-use stall when the producer's data is not yet available.
- Registers the resolved operands into the ID/EX boundary.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register address width.
- DEPTH, 3, number of tracked downstream slots (>=1).
- NUM_SRC, 2, source operands resolved per cycle (>=1).
- LOAD_LAT, 1, lowest slot index at which load data is valid (0..DEPTH-1).
- SEL_W, $clog2(DEPTH+1), forward-select width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hold_in  in  1  global freeze (cache miss etc.).
- flush_in  in  1  kill the ID instruction (branch taken).
- id_valid  in  1  ID stage holds a real instruction.
- id_wen  in  1  ID instruction writes a register.
- id_is_load  in  1  ID instruction is a load.
- id_rd  in  REG_AW  ID destination register.
- id_rs  in  NUM_SRC*REG_AW  source register addresses, source s at [s*REG_AW +: REG_AW].
- rf_data  in  NUM_SRC*DATA_W  register-file read data per source.
- stage_data  in  DEPTH*DATA_W  result currently produced by slot k, at [k*DATA_W +: DATA_W].
- stall_out  out  1  load-use hazard; ID/IF must hold.
- ex_src  out  NUM_SRC*DATA_W  registered resolved operands (ID/EX).
- ex_fwd_sel  out  NUM_SRC*SEL_W  registered source of each operand: 0=regfile, k+1=slot k.

Behaviour:
- Slot state per k: valid, wen, is_load, rd. Reset: all fields 0; ex_src=0; ex_fwd_sel=0; stall_out=0 (follows from empty slots).
- Match for source s at slot k: slot valid & wen & rd==id_rs[s] & id_rs[s]!=0.
- Resolution is combinational and youngest-first: the lowest-k match wins; older matches are ignored.
- Ready rule: a matched slot is ready if not is_load, or if k>=LOAD_LAT.
- Matched and ready: operand = stage_data[k], sel = k+1. No match: operand = rf_data[s], sel = 0. id_rs[s]==0: operand = 0, sel = 0.
- stall_out = id_valid & !flush_in & (any source whose youngest match is not ready). Combinational.
- Per-cycle update, priority hold_in > flush_in > stall_out > normal:
  - hold_in: all slots and outputs registers keep their values.
  - flush_in: slots shift (slot k <= slot k-1); slot0 <= bubble (valid=0); ex_src/ex_fwd_sel <= 0.
  - stall_out: slots shift; slot0 <= bubble; ex_src/ex_fwd_sel <= 0.
  - normal: slots shift; slot0 <= {id_valid, id_wen, id_is_load, id_rd}; ex_src/ex_fwd_sel <= resolved values.
- Operand latency: 1 cycle, ID resolution to ex_src.
- Oldest slot (DEPTH-1) is discarded on shift.
- Load-use with LOAD_LAT=1: exactly one stall cycle. General case: LOAD_LAT-k cycles when the load sits in slot k.
- A flush asserted while hold_in=1 is ignored; upstream keeps flush_in asserted until hold_in drops.
- rst mid-operation clears all slots immediately: in-flight hazards vanish and stall_out deasserts asynchronously.

Decomposition:
- Shared package fwd_pkg: slot record typedef {valid, wen, is_load, rd}; FWD_SEL_RF=0 constant; helper function for slot-select encoding.
- One sub-module, fwd_src_resolve: purely combinational per-source priority match (instantiated NUM_SRC times). Tracker, stall logic and output registers stay in the top.

Test Plan:
- ALU back-to-back: issue add r3 then sub r4,r3 with stage_data[0]=0x11 -> next cycle ex_src[0]=0x11, ex_fwd_sel[0]=1, stall_out never 1.
- Load-use: lw r5 then add r6,r5,r7 -> stall_out=1 for exactly one cycle, bubble enters slot0, ex_fwd_sel=0. Then with stage_data[1]=0xCAFE -> ex_src[0]=0xCAFE, sel=2.
- Priority: r2 written in both slot0 (0xA) and slot2 (0xB), ID reads r2 -> ex_src=0xA, sel=1.
- r0 handling: slot0 writes r0 with stage_data=0xFF, ID reads r0 -> ex_src=0, sel=0, no stall.
- hold/flush: assert hold_in for 3 cycles during a load-use stall -> slots and ex_src unchanged. Then flush_in with the dependent in ID -> stall_out=0, slot0 bubble, ex_src=0.
- Async reset: assert rst mid-cycle with loads in slot0 -> stall_out, ex_src and ex_fwd_sel go 0 before the next clk edge. Rerun with DEPTH=4, NUM_SRC=3, LOAD_LAT=2 -> 2-cycle load-use stall.

Source files
------------

// File: rtl/fwd_pkg.sv
// Purpose: shared types for operand forwarding (tracked slot record, select encoding).
// Latency: declarations only, no timing.
// Backpressure: none.
package fwd_pkg;

  // Widest register address any instance may use; slot rd is stored at this width.
  localparam int REG_AW_MAX = 8;

  // Forward-select code meaning "operand comes from the register file".
  localparam int FWD_SEL_RF = 0;

  // One tracked downstream instruction.
  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic                  is_load;
    logic [REG_AW_MAX-1:0] rd;
  } slot_t;

  // Slot k is reported on the select output as k+1 (0 is reserved for the regfile).
  function automatic int fwd_sel_of_slot(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_resolve.sv
// Purpose: youngest-first match of one source register against the tracked slots.
// Latency: purely combinational.
// Backpressure: raises hazard when the youngest producer's data is not yet valid.
module fwd_src_resolve
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic [REG_AW-1:0]       rs,
  input  logic [DATA_W-1:0]       rf_data,
  input  slot_t [DEPTH-1:0]       slots,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]       operand,
  output logic [SEL_W-1:0]        sel,
  output logic                    hazard
);

  logic found;

  // Scan from slot0 upward; the first match is the youngest producer and shadows older ones.
  always_comb begin
    operand = rf_data;
    sel     = SEL_W'(FWD_SEL_RF);
    hazard  = 1'b0;
    found   = 1'b0;
    if (rs == '0) begin
      // r0 is hard-wired to zero and never forwarded.
      operand = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!found && slots[k].valid && slots[k].wen &&
            slots[k].rd == REG_AW_MAX'(rs)) begin
          found = 1'b1;
          if (!slots[k].is_load || k >= LOAD_LAT) begin
            operand = stage_data[k*DATA_W +: DATA_W];
            sel     = SEL_W'(fwd_sel_of_slot(k));
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/operand_fwd_unit.sv
// Purpose: tracks in-flight destinations, forwards ID operands, detects load-use hazards.
// Latency: 1 cycle from ID resolution to ex_src/ex_fwd_sel; stall_out is combinational.
// Backpressure: stall_out holds ID/IF and injects a bubble; hold_in freezes all state.
module operand_fwd_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hold_in,
  input  logic                      flush_in,
  input  logic                      id_valid,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC*DATA_W-1:0] rf_data,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  output logic                      stall_out,
  output logic [NUM_SRC*DATA_W-1:0] ex_src,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel
);

  // REG_AW must not exceed REG_AW_MAX; rd is zero-extended into the slot record.
  slot_t [DEPTH-1:0]         slots;
  logic [NUM_SRC-1:0]        src_hazard;
  logic [NUM_SRC*DATA_W-1:0] res_src;
  logic [NUM_SRC*SEL_W-1:0]  res_sel;
  logic                      bubble;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_src_resolve #(
      .DATA_W   (DATA_W),
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT),
      .SEL_W    (SEL_W)
    ) u_resolve (
      .rs         (id_rs[s*REG_AW +: REG_AW]),
      .rf_data    (rf_data[s*DATA_W +: DATA_W]),
      .slots      (slots),
      .stage_data (stage_data),
      .operand    (res_src[s*DATA_W +: DATA_W]),
      .sel        (res_sel[s*SEL_W +: SEL_W]),
      .hazard     (src_hazard[s])
    );
  end

  // A killed instruction cannot cause a stall; empty slots (e.g. under reset) never do.
  assign stall_out = id_valid & ~flush_in & (|src_hazard);

  // Flush or stall both send a bubble down the pipe instead of the ID instruction.
  assign bubble = flush_in | stall_out;

  // Destination tracker: shift one slot per unfrozen cycle, oldest slot falls off the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots <= '0;
    end else if (!hold_in) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slots[k] <= slots[k-1];
      end
      if (bubble) begin
        slots[0] <= '0;
      end else begin
        slots[0].valid   <= id_valid;
        slots[0].wen     <= id_wen;
        slots[0].is_load <= id_is_load;
        slots[0].rd      <= REG_AW_MAX'(id_rd);
      end
    end
  end

  // ID/EX operand registers: zeroed on bubble, loaded with resolved operands otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_src     <= '0;
      ex_fwd_sel <= '0;
    end else if (!hold_in) begin
      if (bubble) begin
        ex_src     <= '0;
        ex_fwd_sel <= '0;
      end else begin
        ex_src     <= res_src;
        ex_fwd_sel <= res_sel;
      end
    end
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Purpose: directed checks of forwarding, load-use stalls, hold/flush and async reset.
// Latency: registered outputs sampled 1 time unit after posedge, comb outputs 2 units after.
// Backpressure: stall cycles are counted explicitly against hand-computed expectations.
module tb_operand_fwd_unit;

  logic clk;
  logic rst;

  // Instance A: default parameters (DEPTH=3, NUM_SRC=2, LOAD_LAT=1, SEL_W=2)
  logic        a_hold, a_flush, a_valid, a_wen, a_load;
  logic [4:0]  a_rd;
  logic [9:0]  a_rs;
  logic [63:0] a_rf;
  logic [95:0] a_stage;
  logic        a_stall;
  logic [63:0] a_ex;
  logic [3:0]  a_sel;

  // Instance B: DEPTH=4, NUM_SRC=3, LOAD_LAT=2 (SEL_W=3)
  logic         b_hold, b_flush, b_valid, b_wen, b_load;
  logic [4:0]   b_rd;
  logic [14:0]  b_rs;
  logic [95:0]  b_rf;
  logic [127:0] b_stage;
  logic         b_stall;
  logic [95:0]  b_ex;
  logic [8:0]   b_sel;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fwd_unit dut_a (
    .clk        (clk),
    .rst        (rst),
    .hold_in    (a_hold),
    .flush_in   (a_flush),
    .id_valid   (a_valid),
    .id_wen     (a_wen),
    .id_is_load (a_load),
    .id_rd      (a_rd),
    .id_rs      (a_rs),
    .rf_data    (a_rf),
    .stage_data (a_stage),
    .stall_out  (a_stall),
    .ex_src     (a_ex),
    .ex_fwd_sel (a_sel)
  );

  operand_fwd_unit #(
    .DEPTH    (4),
    .NUM_SRC  (3),
    .LOAD_LAT (2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .hold_in    (b_hold),
    .flush_in   (b_flush),
    .id_valid   (b_valid),
    .id_wen     (b_wen),
    .id_is_load (b_load),
    .id_rd      (b_rd),
    .id_rs      (b_rs),
    .rf_data    (b_rf),
    .stage_data (b_stage),
    .stall_out  (b_stall),
    .ex_src     (b_ex),
    .ex_fwd_sel (b_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_id(input logic v, input logic w, input logic l, input logic [4:0] rd,
                      input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [31:0] rf0, input logic [31:0] rf1);
    a_valid = v; a_wen = w; a_load = l; a_rd = rd;
    a_rs = {rs1, rs0};
    a_rf = {rf1, rf0};
  endtask

  task automatic a_stg(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    a_stage = {s2, s1, s0};
  endtask

  task automatic b_id(input logic v, input logic w, input logic l, input logic [4:0] rd,
                      input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] rf0, input logic [31:0] rf1, input logic [31:0] rf2);
    b_valid = v; b_wen = w; b_load = l; b_rd = rd;
    b_rs = {rs2, rs1, rs0};
    b_rf = {rf2, rf1, rf0};
  endtask

  initial begin
    rst = 1'b1;
    a_hold = 0; a_flush = 0; a_id(0, 0, 0, 0, 0, 0, 0, 0); a_stg(0, 0, 0);
    b_hold = 0; b_flush = 0; b_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); b_stage = '0;

    // Reset state
    #12;
    check_eq("rst_a_stall", a_stall, 0);
    check_eq("rst_a_ex",    a_ex,    0);
    check_eq("rst_a_sel",   a_sel,   0);
    check_eq("rst_b_stall", b_stall, 0);
    check_eq("rst_b_ex",    b_ex,    0);
    check_eq("rst_b_sel",   b_sel,   0);
    #10 rst = 1'b0;
    tick();

    // ALU back-to-back: add r3 ; sub r4,r3,r1
    a_id(1, 1, 0, 3, 1, 2, 32'h100, 32'h200);
    tick();
    check_eq("alu_rf_src0", a_ex[31:0],  32'h100);
    check_eq("alu_rf_src1", a_ex[63:32], 32'h200);
    check_eq("alu_rf_sel",  a_sel,       0);
    a_id(1, 1, 0, 4, 3, 1, 32'h999, 32'h555);
    a_stg(32'h11, 0, 0);
    #1 check_eq("alu_nostall", a_stall, 0);
    tick();
    check_eq("alu_fwd_src0", a_ex[31:0],  32'h11);
    check_eq("alu_fwd_sel0", a_sel[1:0],  1);
    check_eq("alu_fwd_src1", a_ex[63:32], 32'h555);
    check_eq("alu_fwd_sel1", a_sel[3:2],  0);

    // Load-use: lw r5 ; add r6,r5,r7 -> one stall cycle
    a_id(1, 1, 1, 5, 1, 0, 32'h42, 0);
    tick();
    a_id(1, 1, 0, 6, 5, 7, 32'h1234, 32'h77);
    a_stg(32'hDEAD, 0, 0);
    #1 check_eq("lu_stall1", a_stall, 1);
    tick();
    check_eq("lu_bubble_ex",  a_ex,  0);
    check_eq("lu_bubble_sel", a_sel, 0);
    a_stg(32'hDEAD, 32'hCAFE, 0);
    #1 check_eq("lu_stall_end", a_stall, 0);
    tick();
    check_eq("lu_fwd_src0", a_ex[31:0],  32'hCAFE);
    check_eq("lu_fwd_sel0", a_sel[1:0],  2);
    check_eq("lu_rf_src1",  a_ex[63:32], 32'h77);
    check_eq("lu_rf_sel1",  a_sel[3:2],  0);

    // Priority: r2 in slot0 (0xA) and slot2 (0xB); also rs1=r0 with nonzero rf_data
    a_id(1, 1, 0, 2, 0, 0, 0, 0); tick();
    a_id(1, 1, 0, 9, 0, 0, 0, 0); tick();
    a_id(1, 1, 0, 2, 0, 0, 0, 0); tick();
    a_id(1, 0, 0, 0, 2, 0, 32'h3, 32'h4);
    a_stg(32'hA, 32'h5, 32'hB);
    #1 check_eq("prio_nostall", a_stall, 0);
    tick();
    check_eq("prio_src0", a_ex[31:0],  32'hA);
    check_eq("prio_sel0", a_sel[1:0],  1);
    check_eq("prio_r0",   a_ex[63:32], 0);

    // Youngest load shadows an older ready producer of the same register
    a_id(1, 1, 1, 2, 0, 0, 0, 0); tick();
    a_id(1, 0, 0, 0, 2, 0, 32'h3, 0);
    #1 check_eq("shadow_stall", a_stall, 1);
    tick();
    check_eq("shadow_bubble", a_ex[31:0], 0);
    #1 check_eq("shadow_stall_end", a_stall, 0);
    tick();
    check_eq("shadow_src0", a_ex[31:0], 32'h5);
    check_eq("shadow_sel0", a_sel[1:0], 2);

    // r0: load to r0 then read r0 -> no stall, zero operand
    a_id(1, 1, 1, 0, 0, 0, 0, 0); tick();
    a_id(1, 0, 0, 0, 0, 0, 32'h55, 32'h66);
    a_stg(32'hFF, 0, 0);
    #1 check_eq("r0_nostall", a_stall, 0);
    tick();
    check_eq("r0_ex",  a_ex,  0);
    check_eq("r0_sel", a_sel, 0);

    // Hold during a load-use stall, then flush of the dependent
    a_id(1, 1, 1, 8, 1, 0, 32'h4444, 0);
    tick();
    check_eq("hold_pre_src0", a_ex[31:0], 32'h4444);
    a_id(1, 1, 0, 10, 8, 0, 32'h31, 0);
    #1 check_eq("hold_pre_stall", a_stall, 1);
    a_hold = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("hold_src0",  a_ex[31:0], 32'h4444);
      check_eq("hold_stall", a_stall,    1);
    end
    a_flush = 1;
    tick();
    check_eq("hold_flush_src0",  a_ex[31:0], 32'h4444);
    check_eq("hold_flush_stall", a_stall,    0);
    a_hold = 0;
    #1 check_eq("flush_stall", a_stall, 0);
    tick();
    check_eq("flush_ex",  a_ex,  0);
    check_eq("flush_sel", a_sel, 0);
    a_flush = 0;
    a_id(1, 0, 0, 0, 10, 8, 32'h1010, 0);
    a_stg(32'h7, 32'h88, 0);
    #1 check_eq("post_flush_stall", a_stall, 0);
    tick();
    check_eq("post_flush_src0", a_ex[31:0],  32'h1010);
    check_eq("post_flush_sel0", a_sel[1:0],  0);
    check_eq("post_flush_src1", a_ex[63:32], 32'h88);
    check_eq("post_flush_sel1", a_sel[3:2],  2);

    // Async reset mid-cycle with a load in slot0
    a_id(1, 1, 1, 11, 1, 0, 32'h77, 0);
    tick();
    check_eq("ar_pre_src0", a_ex[31:0], 32'h77);
    a_id(1, 1, 0, 12, 11, 0, 0, 0);
    #1 check_eq("ar_pre_stall", a_stall, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_stall", a_stall, 0);
    check_eq("ar_ex",    a_ex,    0);
    check_eq("ar_sel",   a_sel,   0);
    #3 rst = 1'b0;
    a_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Instance B: LOAD_LAT=2 -> two stall cycles, then forwarding from slot2 and slot3
    b_id(1, 1, 1, 5, 0, 0, 0, 0, 0, 0);
    tick();
    b_id(1, 1, 0, 9, 0, 5, 6, 32'h10, 32'h20, 32'h30);
    b_stage = {32'h0, 32'hBEEF, 32'h0, 32'h0};
    #1 check_eq("b_stall1", b_stall, 1);
    tick();
    check_eq("b_bubble1", b_ex[63:32], 0);
    check_eq("b_bsel1",   b_sel[5:3],  0);
    #1 check_eq("b_stall2", b_stall, 1);
    tick();
    check_eq("b_bubble2", b_ex[63:32], 0);
    #1 check_eq("b_stall_end", b_stall, 0);
    tick();
    check_eq("b_src0", b_ex[31:0],  0);
    check_eq("b_sel0", b_sel[2:0],  0);
    check_eq("b_src1", b_ex[63:32], 32'hBEEF);
    check_eq("b_sel1", b_sel[5:3],  3);
    check_eq("b_src2", b_ex[95:64], 32'h30);
    check_eq("b_sel2", b_sel[8:6],  0);
    b_id(1, 0, 0, 0, 5, 9, 0, 32'h1, 32'h2, 32'h3);
    b_stage = {32'h5555, 32'h0, 32'h0, 32'h900};
    #1 check_eq("b_s3_nostall", b_stall, 0);
    tick();
    check_eq("b_s3_src0", b_ex[31:0],  32'h5555);
    check_eq("b_s3_sel0", b_sel[2:0],  4);
    check_eq("b_s0_src1", b_ex[63:32], 32'h900);
    check_eq("b_s0_sel1", b_sel[5:3],  1);
    b_id(1, 0, 0, 0, 5, 0, 0, 32'hABC, 0, 0);
    tick();
    check_eq("b_drop_src0", b_ex[31:0], 32'hABC);
    check_eq("b_drop_sel0", b_sel[2:0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
